phase_countdown_timer: RTL
==========================

// Module: phase_countdown_timer
// PURPOSE
//  Multi-phase countdown timer for the traffic-light controller, successor to the single-phase seconds counter.
//  Cycles through pNUM_PHASES phases (e.g. GREEN/YELLOW/RED). Each phase has its own run-time programmable duration.
//  Counts down on an external 1 Hz tick strobe. Supports hold, plus last/pre_last warning flags.
//  Sits between the tick prescaler and the light-decoding FSM.
// PARAMETERS
//  pWIDTH        7   count/duration width in bits
//  pNUM_PHASES   3   number of phases, >=2; phase index width PW = $clog2(pNUM_PHASES)
//  pDEFAULT_DUR  99  reset duration of every phase; must fit pWIDTH
//  pWARN         1   count value at which pre_last asserts; must be >=1
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       reset, asynchronous, active-low
//  en           in   1       run enable; low = idle/park
//  tick         in   1       single-cycle count strobe (1 per second)
//  hold         in   1       freeze count and phase while high
//  cfg_we       in   1       duration write strobe
//  cfg_idx      in   PW      phase whose duration is written
//  cfg_data     in   pWIDTH  new duration
//  phase        out  PW      current phase index
//  count        out  pWIDTH  current remaining count
//  last         out  1       count==0
//  pre_last     out  1       count==pWARN
//  phase_start  out  1       registered 1-cycle pulse after every phase advance
// BEHAVIOUR
//  Reset: phase=0, count=pDEFAULT_DUR, all durations=pDEFAULT_DUR, phase_start=0.
//  Duration semantics: phase loads dur[p], then counts dur[p]..0. The phase lasts dur[p]+1 ticks. dur=0 gives 1 tick.
//  States: IDLE (en=0), RUN (en=1, hold=0), HOLD (en=1, hold=1). State is implied by inputs; no stored FSM beyond phase/count.
//  IDLE: every clk forces phase=0, count=dur[0], phase_start=0. This is synchronous park, as in the predecessor.
//  RUN, on a clk edge with tick=1:
//    count!=0 -> count-1.
//    count==0 -> phase=(phase==pNUM_PHASES-1)?0:phase+1; count=dur[next]; phase_start=1 next cycle.
//  RUN with tick=0: no change.
//  HOLD: phase and count frozen, tick ignored (ticks are dropped, not queued).
//  Hold release resumes from the frozen count.
//  cfg writes: take effect on the next load only; the running count is never modified.
//  Write to the phase being loaded in the same cycle: the new cfg_data is loaded (write-through).
//  cfg_idx >= pNUM_PHASES: write ignored.
//  last and pre_last: combinational from count, valid in all states.
//  When count==0 during hold, last stays high for the whole hold.
//  en falling mid-phase: next edge parks to phase 0. en rising: first tick decrements dur[0].
//  Async reset mid-phase: immediate return to reset values, including durations.
//  Arithmetic: unsigned pWIDTH; no wrap below 0 (reload is taken instead).
// CONFIGURATION
//  PHASE_COUNTDOWN_TIMER_BCD_EN defined:
//    Adds outputs bcd_tens[3:0] and bcd_units[3:0], a combinational binary-to-BCD conversion of count.
//    count>99 saturates to 9/9. Requires pWIDTH<=7; check with elaboration $error.
//  Undefined: no BCD ports exist; behaviour is otherwise identical.
// STRUCTURE
//  Shared package traffic_pkg:
//    phase encodings PH_GREEN=0, PH_YELLOW=1, PH_RED=2
//    default durations
//    function clog2_min1 for PW (PW>=1)
//  Sub-module phase_dur_regs: pNUM_PHASES x pWIDTH register file.
//    One write port (cfg_we/idx/data) and one combinational read port.
//    Bypass: on an idx match during a write, the read returns cfg_data.
//  Top contains the count/phase datapath, the flags and the optional BCD logic.
// TESTING
//  1. Reset, en=1, tick every cycle, defaults 99:
//     count 99..0 over 100 ticks; phase 0->1; phase_start pulses once; count=99.
//  2. cfg dur[1]=4, dur[2]=0, then run:
//     phase1 lasts 5 ticks, phase2 lasts 1 tick (last high on entry), then wraps to phase 0.
//  3. hold high at count=37 for 10 ticks:
//     count stays 37, phase unchanged. Release: next tick gives 36.
//  4. cfg write to phase 0 at count=50:
//     count unaffected. Next entry to phase 0 loads the new value.
//     A write coinciding with the wrap into phase 0 loads cfg_data.
//  5. en dropped at phase 2, count 12:
//     next cycle phase=0, count=dur[0]. pre_last asserts at count==pWARN=1.
//  6. BCD_EN build, count=47: tens=4, units=7. With pDEFAULT_DUR=120 and pWIDTH=7: 9/9.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timing blocks: phase encodings,
// default durations, run-mode encoding and the phase-index width helper.
package traffic_pkg;

    localparam int unsigned PH_GREEN  = 0;
    localparam int unsigned PH_YELLOW = 1;
    localparam int unsigned PH_RED    = 2;

    localparam int unsigned NUM_PHASES_DEFAULT = 3;
    localparam int unsigned DUR_DEFAULT        = 99;
    localparam int unsigned WARN_DEFAULT       = 1;

    // Run mode is decoded from en/hold each cycle; it is never stored.
    typedef enum logic [1:0] {
        ModeIdle = 2'd0,
        ModeRun  = 2'd1,
        ModeHold = 2'd2
    } mode_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_dur_regs.sv
// Per-phase duration register file: one write port, one combinational read
// port with write-through bypass so a same-cycle write is seen by the reader.
module phase_dur_regs
    import traffic_pkg::*;
#(
    parameter int unsigned pWIDTH       = 7,
    parameter int unsigned pNUM_PHASES  = NUM_PHASES_DEFAULT,
    parameter int unsigned pDEFAULT_DUR = DUR_DEFAULT,
    localparam int unsigned PW          = clog2_min1(pNUM_PHASES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PW-1:0]     cfg_idx,
    input  logic [pWIDTH-1:0] cfg_data,
    input  logic [PW-1:0]     rd_idx,
    output logic [pWIDTH-1:0] rd_data
);

    logic [pWIDTH-1:0] dur_q [pNUM_PHASES];
    logic              wr_ok;

    // Indices beyond the last phase are silently dropped.
    assign wr_ok = cfg_we && (32'(cfg_idx) < pNUM_PHASES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(pNUM_PHASES); i++) begin
                dur_q[i] <= pWIDTH'(pDEFAULT_DUR);
            end
        end else if (wr_ok) begin
            dur_q[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (wr_ok && (cfg_idx == rd_idx)) begin
            rd_data = cfg_data;
        end else if (32'(rd_idx) < pNUM_PHASES) begin
            rd_data = dur_q[rd_idx];
        end
    end

endmodule

// File: rtl/phase_countdown_timer.sv
// Multi-phase countdown timer driven by a 1 Hz tick, with hold and warning flags.
// Optional BCD view of the count is enabled by PHASE_COUNTDOWN_TIMER_BCD_EN.
module phase_countdown_timer
    import traffic_pkg::*;
#(
    parameter int unsigned pWIDTH       = 7,
    parameter int unsigned pNUM_PHASES  = NUM_PHASES_DEFAULT,
    parameter int unsigned pDEFAULT_DUR = DUR_DEFAULT,
    parameter int unsigned pWARN        = WARN_DEFAULT,
    localparam int unsigned PW          = clog2_min1(pNUM_PHASES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              tick,
    input  logic              hold,
    input  logic              cfg_we,
    input  logic [PW-1:0]     cfg_idx,
    input  logic [pWIDTH-1:0] cfg_data,
    output logic [PW-1:0]     phase,
    output logic [pWIDTH-1:0] count,
    output logic              last,
    output logic              pre_last,
    output logic              phase_start
`ifdef PHASE_COUNTDOWN_TIMER_BCD_EN
    ,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_units
`endif
);

    if (pNUM_PHASES < 2) begin : g_chk_phases
        $error("phase_countdown_timer: pNUM_PHASES must be >= 2");
    end
    if (pWARN < 1) begin : g_chk_warn
        $error("phase_countdown_timer: pWARN must be >= 1");
    end
    if (pDEFAULT_DUR >= (64'd1 << pWIDTH)) begin : g_chk_dur
        $error("phase_countdown_timer: pDEFAULT_DUR does not fit pWIDTH");
    end

    logic [PW-1:0]     phase_q, phase_d;
    logic [pWIDTH-1:0] count_q, count_d;
    logic              phase_start_q, phase_start_d;
    logic [PW-1:0]     next_phase;
    logic [PW-1:0]     rd_idx;
    logic [pWIDTH-1:0] rd_dur;
    mode_e             mode;

    phase_dur_regs #(
        .pWIDTH       (pWIDTH),
        .pNUM_PHASES  (pNUM_PHASES),
        .pDEFAULT_DUR (pDEFAULT_DUR)
    ) u_dur_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .rd_idx   (rd_idx),
        .rd_data  (rd_dur)
    );

    always_comb begin
        if (!en) begin
            mode = ModeIdle;
        end else if (hold) begin
            mode = ModeHold;
        end else begin
            mode = ModeRun;
        end
    end

    assign next_phase = (phase_q == PW'(pNUM_PHASES - 1)) ? '0 : phase_q + PW'(1);

    // The only loads are the idle park (phase 0) and a run-mode advance.
    assign rd_idx = (mode == ModeRun) ? next_phase : '0;

    always_comb begin
        phase_d       = phase_q;
        count_d       = count_q;
        phase_start_d = 1'b0;
        unique case (mode)
            ModeIdle: begin
                phase_d = '0;
                count_d = rd_dur;
            end
            ModeRun: begin
                if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - pWIDTH'(1);
                    end else begin
                        phase_d       = next_phase;
                        count_d       = rd_dur;
                        phase_start_d = 1'b1;
                    end
                end
            end
            ModeHold: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            count_q       <= pWIDTH'(pDEFAULT_DUR);
            phase_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            count_q       <= count_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign phase       = phase_q;
    assign count       = count_q;
    assign phase_start = phase_start_q;
    assign last        = (count_q == '0);
    assign pre_last    = (count_q == pWIDTH'(pWARN));

`ifdef PHASE_COUNTDOWN_TIMER_BCD_EN
    if (pWIDTH > 7) begin : g_chk_bcd
        $error("phase_countdown_timer: BCD output requires pWIDTH <= 7");
    end

    int unsigned count_u;

    always_comb begin
        count_u = 32'(count_q);
        if (count_u > 99) begin
            bcd_tens  = 4'd9;
            bcd_units = 4'd9;
        end else begin
            bcd_tens  = 4'(count_u / 10);
            bcd_units = 4'(count_u % 10);
        end
    end
`endif

endmodule
